// File: rtl/pe_seq_pkg.sv
// Shared encodings and per-mode constants for the bit-serial PE sequencer.
package pe_seq_pkg;

    typedef enum logic [1:0] {
        MODE_2B  = 2'd0,
        MODE_4B  = 2'd1,
        MODE_8B  = 2'd2,
        MODE_RSV = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_e;

    localparam int PE_MAX_SHIFT = 8;

    localparam int S_2B = 1;
    localparam int S_4B = 2;
    localparam int S_8B = 4;
    localparam int N_2B = S_2B * S_2B;
    localparam int N_4B = S_4B * S_4B;
    localparam int N_8B = S_8B * S_8B;

    // The reserved encoding runs as 8b so a stray mode never hangs the sequencer.
    function automatic int slices_of(input logic [1:0] mode);
        case (mode)
            MODE_2B: return S_2B;
            MODE_4B: return S_4B;
            default: return S_8B;
        endcase
    endfunction

    function automatic logic [3:0] last_pass(input logic [1:0] mode);
        case (mode)
            MODE_2B: return 4'(N_2B - 1);
            MODE_4B: return 4'(N_4B - 1);
            default: return 4'(N_8B - 1);
        endcase
    endfunction

endpackage

// File: rtl/pe_slice_gather.sv
// Maps one latched beat and pass index onto the 16 two-bit PE lanes, plus shift split.
module pe_slice_gather
    import pe_seq_pkg::*;
(
    input  logic        en,
    input  logic [31:0] act,
    input  logic [31:0] wgt,
    input  logic [1:0]  mode,
    input  logic        a_signed,
    input  logic        w_signed,
    input  logic [3:0]  pass_idx,
    output logic [31:0] pe_activation,
    output logic [31:0] pe_weight,
    output logic        pe_a_signed,
    output logic        pe_w_signed,
    output logic [3:0]  pe_shift_amount,
    output logic [2:0]  residual
);

    int         s;
    int         total;
    int         pe_shift;
    logic [1:0] ia;
    logic [1:0] jw;
    logic [4:0] a_idx;
    logic [4:0] w_idx;

    always_comb begin
        pe_activation   = '0;
        pe_weight       = '0;
        pe_a_signed     = 1'b0;
        pe_w_signed     = 1'b0;
        pe_shift_amount = '0;
        residual        = '0;
        a_idx           = '0;
        w_idx           = '0;
        total           = 0;
        pe_shift        = 0;
        s               = slices_of(mode);
        case (s)
            1: begin ia = 2'd0;            jw = 2'd0;            end
            2: begin ia = {1'b0, pass_idx[1]}; jw = {1'b0, pass_idx[0]}; end
            default: begin ia = pass_idx[3:2]; jw = pass_idx[1:0]; end
        endcase
        if (en) begin
            // Element k occupies 2*s bits; only the first 16/s lanes carry data.
            for (int k = 0; k < 16; k++) begin
                if (k * s < 16) begin
                    a_idx = 5'(2 * k * s + 2 * int'(ia));
                    w_idx = 5'(2 * k * s + 2 * int'(jw));
                    pe_activation[2*k +: 2] = act[a_idx +: 2];
                    pe_weight[2*k +: 2]     = wgt[w_idx +: 2];
                end
            end
            pe_a_signed     = a_signed && (int'(ia) == s - 1);
            pe_w_signed     = w_signed && (int'(jw) == s - 1);
            total           = 2 * (int'(ia) + int'(jw));
            pe_shift        = (total > PE_MAX_SHIFT) ? PE_MAX_SHIFT : total;
            pe_shift_amount = 4'(pe_shift);
            residual        = 3'(total - pe_shift);
        end
    end

endmodule

// File: rtl/pe_seq_ctrl.sv
// Sequences multi-precision beats through a 2b-slice PE and accumulates the group sum.
// Optional PE_SEQ_SAT_EN: saturating accumulate with sticky o_ovf (default wraps).
module pe_seq_ctrl
    import pe_seq_pkg::*;
#(
    parameter int ACC_W = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic [31:0]             i_req_act,
    input  logic [31:0]             i_req_wgt,
    input  logic [1:0]              i_req_mode,
    input  logic                    i_req_a_signed,
    input  logic                    i_req_w_signed,
    input  logic                    i_req_last,
    output logic [31:0]             o_pe_activation,
    output logic [31:0]             o_pe_weight,
    output logic                    o_pe_A_signed,
    output logic                    o_pe_W_signed,
    output logic [3:0]              o_pe_shift_amount,
    input  logic signed [16:0]      i_pe_prod,
    output logic                    o_res_valid,
    input  logic                    i_res_ready,
    output logic signed [ACC_W-1:0] o_res_data,
    output logic                    o_busy,
    output logic                    o_ovf
);

    localparam int SUM_W = ((ACC_W > 21) ? ACC_W : 21) + 2;

    state_e                  state;
    state_e                  state_next;
    logic [3:0]              pass_cnt;
    logic [31:0]             act_q;
    logic [31:0]             wgt_q;
    logic [1:0]              mode_q;
    logic                    a_signed_q;
    logic                    w_signed_q;
    logic                    last_q;
    logic                    accept;
    logic [2:0]              residual;
    logic [2:0]              residual_d;
    logic                    valid_d;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [SUM_W-1:0] term;
    logic signed [SUM_W-1:0] sum_full;
    logic                    ovf;
    logic                    clamp;

    pe_slice_gather u_gather (
        .en              (state == ISSUE),
        .act             (act_q),
        .wgt             (wgt_q),
        .mode            (mode_q),
        .a_signed        (a_signed_q),
        .w_signed        (w_signed_q),
        .pass_idx        (pass_cnt),
        .pe_activation   (o_pe_activation),
        .pe_weight       (o_pe_weight),
        .pe_a_signed     (o_pe_A_signed),
        .pe_w_signed     (o_pe_W_signed),
        .pe_shift_amount (o_pe_shift_amount),
        .residual        (residual)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next  = state;
        o_req_ready = 1'b0;
        o_res_valid = 1'b0;
        case (state)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) state_next = ISSUE;
            end
            ISSUE: if (pass_cnt == last_pass(mode_q)) state_next = DRAIN;
            DRAIN: state_next = last_q ? OUT : IDLE;
            OUT: begin
                o_res_valid = 1'b1;
                if (i_res_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = o_req_ready && i_req_valid;

    // The PE product lags its inputs by one cycle, so residual shift rides along delayed.
    always_comb begin
        term     = {{(SUM_W-17){i_pe_prod[16]}}, i_pe_prod} <<< residual_d;
        sum_full = {{(SUM_W-ACC_W){acc[ACC_W-1]}}, acc} + term;
`ifdef PE_SEQ_SAT_EN
        if (sum_full > $signed({{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}})) begin
            clamp    = 1'b1;
            acc_next = {1'b0, {(ACC_W-1){1'b1}}};
        end else if (sum_full < $signed({{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}})) begin
            clamp    = 1'b1;
            acc_next = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            clamp    = 1'b0;
            acc_next = ACC_W'(sum_full);
        end
`else
        clamp    = 1'b0;
        acc_next = ACC_W'(sum_full);
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pass_cnt   <= '0;
            act_q      <= '0;
            wgt_q      <= '0;
            mode_q     <= '0;
            a_signed_q <= 1'b0;
            w_signed_q <= 1'b0;
            last_q     <= 1'b0;
            valid_d    <= 1'b0;
            residual_d <= '0;
            acc        <= '0;
            ovf        <= 1'b0;
        end else begin
            valid_d    <= (state == ISSUE);
            residual_d <= residual;
            if (accept) begin
                act_q      <= i_req_act;
                wgt_q      <= i_req_wgt;
                mode_q     <= i_req_mode;
                a_signed_q <= i_req_a_signed;
                w_signed_q <= i_req_w_signed;
                last_q     <= i_req_last;
                pass_cnt   <= '0;
            end else if (state == ISSUE) begin
                pass_cnt <= pass_cnt + 4'd1;
            end
            if (state == OUT && i_res_ready) begin
                acc <= '0;
                ovf <= 1'b0;
            end else if (valid_d) begin
                acc <= acc_next;
                ovf <= ovf | clamp;
            end
        end
    end

    assign o_res_data = acc;
    assign o_ovf      = ovf;
    assign o_busy     = (state != IDLE);

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed bench for pe_seq_ctrl: a 32-bit instance for the main scenarios and a
// 16-bit instance for the accumulator-overflow case; the PE is modelled in the bench.
module tb_pe_seq_ctrl;

    logic               i_clk = 1'b0;
    logic               i_rst_n = 1'b0;
    logic               i_req_valid = 1'b0;
    logic               i_req_valid16 = 1'b0;
    logic [31:0]        i_req_act = '0;
    logic [31:0]        i_req_wgt = '0;
    logic [1:0]         i_req_mode = '0;
    logic               i_req_a_signed = 1'b0;
    logic               i_req_w_signed = 1'b0;
    logic               i_req_last = 1'b0;
    logic               i_res_ready = 1'b0;

    logic               req_ready, req_ready16;
    logic [31:0]        pe_act, pe_wgt, pe_act16, pe_wgt16;
    logic               pe_as, pe_ws, pe_as16, pe_ws16;
    logic [3:0]         pe_sh, pe_sh16;
    logic signed [16:0] pe_prod = '0;
    logic signed [16:0] pe_prod16 = '0;
    logic               res_valid, res_valid16;
    logic signed [31:0] res_data;
    logic signed [15:0] res_data16;
    logic               busy, busy16, ovf, ovf16;

    int errors = 0;
    int checks = 0;
    int cyc;

    always #5 i_clk = ~i_clk;

    pe_seq_ctrl #(.ACC_W(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(req_ready),
        .i_req_act(i_req_act), .i_req_wgt(i_req_wgt), .i_req_mode(i_req_mode),
        .i_req_a_signed(i_req_a_signed), .i_req_w_signed(i_req_w_signed), .i_req_last(i_req_last),
        .o_pe_activation(pe_act), .o_pe_weight(pe_wgt),
        .o_pe_A_signed(pe_as), .o_pe_W_signed(pe_ws), .o_pe_shift_amount(pe_sh),
        .i_pe_prod(pe_prod),
        .o_res_valid(res_valid), .i_res_ready(i_res_ready), .o_res_data(res_data),
        .o_busy(busy), .o_ovf(ovf)
    );

    pe_seq_ctrl #(.ACC_W(16)) dut16 (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid16), .o_req_ready(req_ready16),
        .i_req_act(i_req_act), .i_req_wgt(i_req_wgt), .i_req_mode(i_req_mode),
        .i_req_a_signed(i_req_a_signed), .i_req_w_signed(i_req_w_signed), .i_req_last(i_req_last),
        .o_pe_activation(pe_act16), .o_pe_weight(pe_wgt16),
        .o_pe_A_signed(pe_as16), .o_pe_W_signed(pe_ws16), .o_pe_shift_amount(pe_sh16),
        .i_pe_prod(pe_prod16),
        .o_res_valid(res_valid16), .i_res_ready(i_res_ready), .o_res_data(res_data16),
        .o_busy(busy16), .o_ovf(ovf16)
    );

    // Behavioural PE: dot product of sixteen 2-bit lanes, shifted, registered one cycle.
    function automatic logic signed [16:0] peModel(input logic [31:0] a, input logic [31:0] w,
                                                   input logic as_, input logic ws_,
                                                   input logic [3:0] sh);
        int sum = 0;
        int av, wv;
        for (int k = 0; k < 16; k++) begin
            av  = as_ ? int'($signed(a[2*k +: 2])) : int'(a[2*k +: 2]);
            wv  = ws_ ? int'($signed(w[2*k +: 2])) : int'(w[2*k +: 2]);
            sum = sum + av * wv;
        end
        return 17'(sum <<< sh);
    endfunction

    always @(posedge i_clk) begin
        pe_prod   <= peModel(pe_act, pe_wgt, pe_as, pe_ws, pe_sh);
        pe_prod16 <= peModel(pe_act16, pe_wgt16, pe_as16, pe_ws16, pe_sh16);
    end

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Presents one beat and returns 1 time unit after the accepting edge.
    task automatic applyStimulus(input bit use16, input logic [31:0] act, input logic [31:0] wgt,
                                 input logic [1:0] mode, input logic as_, input logic ws_,
                                 input logic last);
        @(negedge i_clk);
        i_req_act      = act;
        i_req_wgt      = wgt;
        i_req_mode     = mode;
        i_req_a_signed = as_;
        i_req_w_signed = ws_;
        i_req_last     = last;
        if (use16) i_req_valid16 = 1'b1;
        else       i_req_valid   = 1'b1;
        #1 checkOutput("req_ready_before_accept", use16 ? req_ready16 : req_ready, 1);
        @(posedge i_clk);
        #1;
        i_req_valid   = 1'b0;
        i_req_valid16 = 1'b0;
    endtask

    task automatic stepCycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic waitResult(input bit use16, output int cycles);
        cycles = 0;
        while (((use16 ? res_valid16 : res_valid) == 1'b0) && cycles < 64) begin
            stepCycle();
            cycles++;
        end
    endtask

    task automatic takeResult();
        @(negedge i_clk);
        i_res_ready = 1'b1;
        stepCycle();
        i_res_ready = 1'b0;
    endtask

    int   exp_shift [4] = '{0, 2, 2, 4};
    logic exp_as    [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic exp_ws    [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    // Latency is counted in edges after the accepting edge; with the accept cycle
    // counted as cycle 1, o_res_valid appears in cycle N+2, i.e. N+1 edges later.
    initial begin
        repeat (2) @(posedge i_clk);
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_res_valid", res_valid, 0);
        checkOutput("reset_res_data", res_data, 0);
        checkOutput("reset_ovf", ovf, 0);
        checkOutput("reset_pe_shift", pe_sh, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1 checkOutput("idle_req_ready", req_ready, 1);

        // 2b unsigned single beat
        applyStimulus(0, 32'h5555_5555, 32'h5555_5555, 2'd0, 0, 0, 1);
        checkOutput("s1_pe_act", pe_act, 32'h5555_5555);
        checkOutput("s1_pe_shift", pe_sh, 0);
        checkOutput("s1_busy", busy, 1);
        checkOutput("s1_req_ready_busy", req_ready, 0);
        waitResult(0, cyc);
        checkOutput("s1_latency", cyc, 2);
        checkOutput("s1_res_data", res_data, 16);
        takeResult();
        checkOutput("s1_res_valid_after", res_valid, 0);
        checkOutput("s1_acc_cleared", res_data, 0);

        // 4b signed: -3 * 5
        applyStimulus(0, 32'h0000_000D, 32'h0000_0005, 2'd1, 1, 1, 1);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("s2_shift_p%0d", i), pe_sh, exp_shift[i]);
            checkOutput($sformatf("s2_asgn_p%0d", i), pe_as, exp_as[i]);
            checkOutput($sformatf("s2_wsgn_p%0d", i), pe_ws, exp_ws[i]);
            if (i < 3) stepCycle();
        end
        waitResult(0, cyc);
        checkOutput("s2_latency", 3 + cyc, 5);
        checkOutput("s2_res_data", res_data, -15);
        takeResult();

        // 8b signed: -128 * -128, only the top-slice pass contributes
        applyStimulus(0, 32'h0000_0080, 32'h0000_0080, 2'd2, 1, 1, 1);
        repeat (15) stepCycle();
        checkOutput("s3_pe_shift_p15", pe_sh, 8);
        checkOutput("s3_pe_act_p15", pe_act, 32'h0000_0002);
        checkOutput("s3_pe_wgt_p15", pe_wgt, 32'h0000_0002);
        checkOutput("s3_asgn_p15", pe_as, 1);
        waitResult(0, cyc);
        checkOutput("s3_latency", 15 + cyc, 17);
        checkOutput("s3_res_data", res_data, 16384);
        takeResult();

        // reserved mode runs as 8b: 3 * 5
        applyStimulus(0, 32'h0000_0003, 32'h0000_0005, 2'd3, 0, 0, 1);
        waitResult(0, cyc);
        checkOutput("mode3_latency", cyc, 17);
        checkOutput("mode3_res_data", res_data, 15);
        takeResult();

        // two-beat group with back-pressure on the result
        applyStimulus(0, 32'h5555_5555, 32'h5555_5555, 2'd0, 0, 0, 0);
        repeat (2) stepCycle();
        checkOutput("s4_mid_busy", busy, 0);
        checkOutput("s4_mid_res_valid", res_valid, 0);
        checkOutput("s4_mid_acc", res_data, 16);
        applyStimulus(0, 32'h5555_5555, 32'h5555_5555, 2'd0, 0, 0, 1);
        waitResult(0, cyc);
        checkOutput("s4_latency", cyc, 2);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("s4_hold_valid_%0d", i), res_valid, 1);
            checkOutput($sformatf("s4_hold_data_%0d", i), res_data, 32);
            checkOutput($sformatf("s4_hold_ready_%0d", i), req_ready, 0);
            stepCycle();
        end
        takeResult();
        checkOutput("s4_after_busy", busy, 0);
        checkOutput("s4_after_req_ready", req_ready, 1);

        // asynchronous reset during pass 5 of an 8b beat
        applyStimulus(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd2, 0, 0, 1);
        repeat (5) stepCycle();
        #2 i_rst_n = 1'b0;
        #1;
        checkOutput("s5_rst_busy", busy, 0);
        checkOutput("s5_rst_res_valid", res_valid, 0);
        checkOutput("s5_rst_res_data", res_data, 0);
        checkOutput("s5_rst_pe_act", pe_act, 0);
        checkOutput("s5_rst_pe_shift", pe_sh, 0);
        checkOutput("s5_rst_ovf", ovf, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        applyStimulus(0, 32'h5555_5555, 32'h5555_5555, 2'd0, 0, 0, 1);
        waitResult(0, cyc);
        checkOutput("s5_latency", cyc, 2);
        checkOutput("s5_res_data", res_data, 16);
        takeResult();

        // 16-bit accumulator, 4 x 255 * 255 = 260100
        applyStimulus(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd2, 0, 0, 1);
        waitResult(1, cyc);
        checkOutput("s6_latency", cyc, 17);
`ifdef PE_SEQ_SAT_EN
        checkOutput("s6_res_data", res_data16, 32767);
        checkOutput("s6_ovf", ovf16, 1);
`else
        checkOutput("s6_res_data", res_data16, -2044);
        checkOutput("s6_ovf", ovf16, 0);
`endif
        takeResult();
        checkOutput("s6_ovf_cleared", ovf16, 0);
        checkOutput("s6_acc_cleared", res_data16, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
